// File: rtl/onc16_pl.sv
// onc16_pl: 16-bit four-stage (IF, ID, EX, MEM/WB) pipelined core.
// MEM/WB results are forwarded into EX, so there are no stalls. Taken branches squash two slots.
module onc16_pl #(
    parameter int DATA_W = 16,
    parameter int INST_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en,
    input  logic [INST_W-1:0] imem_din,
    input  logic [DATA_W-1:0] dmem_din,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_dout,
    output logic              dmem_we
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LDH  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_BNZ  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {RUN, HALTED} run_state_t;

    run_state_t        run_state;
    logic [DATA_W-1:0] pc;
    logic [INST_W-1:0] id_inst;
    logic [INST_W-1:0] ex_inst;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] rf [NREG];

    logic              wb_en;
    logic              wb_load;
    logic              mem_we;
    logic [2:0]        wb_rd;
    logic [DATA_W-1:0] wb_val;
    logic [DATA_W-1:0] wb_data;

    logic [3:0]        ex_op;
    logic [2:0]        ex_rd;
    logic [2:0]        ex_rs;
    logic [2:0]        ex_rt;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] opc;
    logic [DATA_W-1:0] sext8;
    logic [DATA_W-1:0] sext12;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] br_target;
    logic              ex_writes;
    logic              br_taken;
    logic              id_halt;

    assign imem_addr = pc;
    assign dmem_we   = mem_we & en;

    assign id_halt = (id_inst[15:12] == OP_HALT);

    assign ex_op  = ex_inst[15:12];
    assign ex_rd  = ex_inst[11:9];
    assign ex_rs  = ex_inst[8:6];
    assign ex_rt  = ex_inst[5:3];
    assign sext8  = {{(DATA_W-8){ex_inst[7]}}, ex_inst[7:0]};
    assign sext12 = {{(DATA_W-12){ex_inst[11]}}, ex_inst[11:0]};

    // A load's data only exists on dmem_din during its MEM/WB cycle, so it is forwarded from there
    assign wb_data = wb_load ? dmem_din : wb_val;

    assign opa = (ex_rs == 3'd0) ? '0 : (wb_en && wb_rd == ex_rs) ? wb_data : rf[ex_rs];
    assign opb = (ex_rt == 3'd0) ? '0 : (wb_en && wb_rd == ex_rt) ? wb_data : rf[ex_rt];
    assign opc = (ex_rd == 3'd0) ? '0 : (wb_en && wb_rd == ex_rd) ? wb_data : rf[ex_rd];

    always_comb begin
        alu_out   = '0;
        ex_writes = 1'b0;
        br_taken  = 1'b0;
        br_target = ex_pc + sext8;
        case (ex_op)
            OP_ADD: begin alu_out = opa + opb;          ex_writes = 1'b1; end
            OP_SUB: begin alu_out = opa - opb;          ex_writes = 1'b1; end
            OP_AND: begin alu_out = opa & opb;          ex_writes = 1'b1; end
            OP_OR:  begin alu_out = opa | opb;          ex_writes = 1'b1; end
            OP_XOR: begin alu_out = opa ^ opb;          ex_writes = 1'b1; end
            OP_SHL: begin alu_out = opa << opb[3:0];    ex_writes = 1'b1; end
            OP_SHR: begin alu_out = opa >> opb[3:0];    ex_writes = 1'b1; end
            OP_LDI: begin alu_out = sext8;              ex_writes = 1'b1; end
            OP_LDH: begin alu_out = {ex_inst[7:0], opc[7:0]}; ex_writes = 1'b1; end
            OP_LD:  ex_writes = 1'b1;
            OP_BZ:  br_taken = (opc == '0);
            OP_BNZ: br_taken = (opc != '0);
            OP_JMP: begin
                br_taken  = 1'b1;
                br_target = ex_pc + sext12;
            end
            default: ;
        endcase
    end

    // A taken branch in EX outranks a HALT sitting in ID, which gets squashed with the other young slot
    always_ff @(posedge clock) begin
        if (rst) begin
            pc        <= '0;
            run_state <= RUN;
            id_inst   <= '0;
            id_pc     <= '0;
            ex_inst   <= '0;
            ex_pc     <= '0;
            wb_en     <= 1'b0;
            wb_load   <= 1'b0;
            wb_rd     <= '0;
            wb_val    <= '0;
            mem_we    <= 1'b0;
            dmem_addr <= '0;
            dmem_dout <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (en) begin
            if (wb_en) rf[wb_rd] <= wb_data;
            wb_en   <= ex_writes && (ex_rd != 3'd0);
            wb_rd   <= ex_rd;
            wb_val  <= alu_out;
            wb_load <= (ex_op == OP_LD);
            mem_we  <= (ex_op == OP_ST);
            if (ex_op == OP_LD || ex_op == OP_ST) dmem_addr <= opa;
            if (ex_op == OP_ST) dmem_dout <= opb;

            if (br_taken) begin
                pc      <= br_target;
                id_inst <= '0;
                ex_inst <= '0;
            end else begin
                ex_inst <= id_inst;
                ex_pc   <= id_pc;
                if (run_state == HALTED || id_halt) begin
                    run_state <= HALTED;
                    id_inst   <= '0;
                end else begin
                    pc      <= pc + DATA_W'(1);
                    id_inst <= imem_din;
                    id_pc   <= pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_onc16_pl.sv
// Bench for onc16_pl: an instruction-level model predicts every store,
// and a monitor compares each DUT store strobe against that prediction.
module tb_onc16_pl;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] imem_din;
    logic [15:0] dmem_din;
    logic [15:0] imem_addr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_dout;
    logic        dmem_we;

    onc16_pl dut (
        .clock     (clock),
        .rst       (rst),
        .en        (en),
        .imem_din  (imem_din),
        .dmem_din  (dmem_din),
        .imem_addr (imem_addr),
        .dmem_addr (dmem_addr),
        .dmem_dout (dmem_dout),
        .dmem_we   (dmem_we)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } store_t;

    logic [15:0] imem [65536];
    logic [15:0] dram [65536];
    logic [15:0] mmem [65536];
    store_t      exp_q [$];
    logic [15:0] addr_trace [$];
    logic [15:0] exp_halt;
    int          total = 0;
    int          bad = 0;

    assign imem_din = imem[imem_addr];
    assign dmem_din = dram[dmem_addr];

    always @(posedge clock) if (dmem_we) dram[dmem_addr] = dmem_dout;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every store strobe consumes one predicted store
    always @(negedge clock) begin
        if (!rst && dmem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_store: got addr=%h data=%h expected no store", dmem_addr, dmem_dout);
            end else begin
                store_t s;
                s = exp_q.pop_front();
                check_output("store_addr", dmem_addr, s.addr);
                check_output("store_data", dmem_dout, s.data);
            end
        end
        if (!rst && !en) check_output("we_gated", {15'd0, dmem_we}, 16'd0);
    end

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic init_mem(input logic [15:0] seed);
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 16'hF000;
            dram[i] = 16'(i) * 16'h9E37 ^ seed;
            mmem[i] = dram[i];
        end
    endtask

    // Sequential instruction-set model: one instruction per step, no pipeline
    task automatic run_model(output logic [15:0] halt_pc);
        logic [15:0] r [8];
        logic [15:0] pc, inst, a, b, c, v, nxt;
        logic [3:0]  op;
        logic [2:0]  rd;
        bit          wr;
        bit          done;
        for (int i = 0; i < 8; i++) r[i] = 16'd0;
        pc = 16'd0;
        done = 0;
        halt_pc = 16'd0;
        for (int step = 0; step < 20000 && !done; step++) begin
            inst = imem[pc];
            op = inst[15:12];
            rd = inst[11:9];
            a = r[inst[8:6]];
            b = r[inst[5:3]];
            c = r[rd];
            v = 16'd0;
            wr = 0;
            nxt = pc + 16'd1;
            case (op)
                4'h1: begin v = a + b; wr = 1; end
                4'h2: begin v = a - b; wr = 1; end
                4'h3: begin v = a & b; wr = 1; end
                4'h4: begin v = a | b; wr = 1; end
                4'h5: begin v = a ^ b; wr = 1; end
                4'h6: begin v = a << b[3:0]; wr = 1; end
                4'h7: begin v = a >> b[3:0]; wr = 1; end
                4'h8: begin v = {{8{inst[7]}}, inst[7:0]}; wr = 1; end
                4'h9: begin v = {inst[7:0], c[7:0]}; wr = 1; end
                4'hA: begin v = mmem[a]; wr = 1; end
                4'hB: begin mmem[a] = b; exp_q.push_back({a, b}); end
                4'hC: if (c == 16'd0) nxt = pc + {{8{inst[7]}}, inst[7:0]};
                4'hD: if (c != 16'd0) nxt = pc + {{8{inst[7]}}, inst[7:0]};
                4'hE: nxt = pc + {{4{inst[11]}}, inst[11:0]};
                4'hF: begin halt_pc = pc; done = 1; end
                default: ;
            endcase
            if (wr && rd != 3'd0) r[rd] = v;
            if (!done) pc = nxt;
        end
    endtask

    task automatic reset_dut();
        @(posedge clock);
        #1 rst = 1'b1;
        en = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1 rst = 1'b0;
        addr_trace.delete();
    endtask

    task automatic start_program();
        reset_dut();
        run_model(exp_halt);
    endtask

    task automatic step_cycles(input int n, input logic en_val);
        repeat (n) begin
            @(posedge clock);
            #1 en = en_val;
        end
    endtask

    // Run until every predicted store has been seen, then confirm the core parks after HALT
    task automatic apply_stimulus(input bit rand_en);
        int cyc;
        for (cyc = 0; cyc < 4000; cyc++) begin
            addr_trace.push_back(imem_addr);
            if (exp_q.size() == 0) break;
            @(posedge clock);
            #1 en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        en = 1'b1;
        step_cycles(12, 1'b1);
        check_output("halt_pc", imem_addr, exp_halt + 16'd1);
    endtask

    task automatic load_fib();
        imem[0] = enc_i(4'h8, 3'd2, 8'd1);
        imem[1] = enc_i(4'h8, 3'd4, 8'd10);
        imem[2] = enc_i(4'h8, 3'd5, 8'hFF);
        imem[3] = enc_r(4'hB, 3'd0, 3'd0, 3'd2);
        imem[4] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
        imem[5] = enc_r(4'h1, 3'd1, 3'd2, 3'd0);
        imem[6] = enc_r(4'h1, 3'd2, 3'd3, 3'd0);
        imem[7] = enc_r(4'h1, 3'd4, 3'd4, 3'd5);
        imem[8] = enc_i(4'hD, 3'd4, 8'hFB);
        imem[9] = 16'hF000;
    endtask

    task automatic gen_random(input int len);
        logic [3:0] op;
        int         maxo;
        int         off;
        for (int pos = 0; pos < len; pos++) begin
            op = 4'($urandom_range(0, 14));
            maxo = len - pos;
            if (maxo > 127) maxo = 127;
            off = int'($urandom_range(1, maxo));
            case (op)
                4'hC, 4'hD: imem[pos] = enc_i(op, 3'($urandom), 8'(off));
                4'hE:       imem[pos] = {4'hE, 12'(off)};
                4'h8, 4'h9: imem[pos] = enc_i(op, 3'($urandom), 8'($urandom));
                default:    imem[pos] = enc_r(op, 3'($urandom), 3'($urandom), 3'($urandom));
            endcase
        end
        for (int k = 1; k < 8; k++) imem[len + k - 1] = enc_r(4'hB, 3'd0, 3'd0, 3'(k));
        imem[len + 7] = 16'hF000;
    endtask

    initial begin
        int idx;
        init_mem(16'h0000);
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_imem_addr", imem_addr, 16'd0);
        check_output("rst_dmem_addr", dmem_addr, 16'd0);
        check_output("rst_dmem_dout", dmem_dout, 16'd0);
        check_output("rst_dmem_we", {15'd0, dmem_we}, 16'd0);

        $display("[TB] basic add/store");
        init_mem(16'h1111);
        imem[0] = enc_i(4'h8, 3'd1, 8'd5);
        imem[1] = enc_i(4'h8, 3'd2, 8'd7);
        imem[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
        imem[3] = enc_r(4'hB, 3'd0, 3'd0, 3'd3);
        start_program();
        apply_stimulus(0);

        $display("[TB] back-to-back forwarding");
        init_mem(16'h2222);
        imem[0] = enc_i(4'h8, 3'd1, 8'hFF);
        imem[1] = enc_r(4'h1, 3'd2, 3'd1, 3'd1);
        imem[2] = enc_r(4'h2, 3'd3, 3'd2, 3'd1);
        imem[3] = enc_r(4'hB, 3'd0, 3'd0, 3'd3);
        start_program();
        apply_stimulus(0);

        $display("[TB] load-use forwarding");
        init_mem(16'h3333);
        dram[0] = 16'h1234;
        mmem[0] = 16'h1234;
        imem[0] = enc_r(4'hA, 3'd1, 3'd0, 3'd0);
        imem[1] = enc_r(4'h1, 3'd2, 3'd1, 3'd1);
        imem[2] = enc_r(4'hB, 3'd0, 3'd0, 3'd2);
        start_program();
        apply_stimulus(0);

        $display("[TB] taken branch flush");
        init_mem(16'h4444);
        imem[0] = enc_i(4'h8, 3'd1, 8'd1);
        imem[1] = enc_r(4'h5, 3'd2, 3'd2, 3'd1);
        imem[2] = enc_r(4'hB, 3'd0, 3'd0, 3'd2);
        imem[3] = 16'h0000;
        imem[4] = enc_i(4'hD, 3'd2, 8'hFD);
        imem[5] = enc_r(4'hB, 3'd0, 3'd0, 3'd1);
        imem[6] = enc_i(4'h8, 3'd2, 8'd9);
        imem[7] = enc_r(4'hB, 3'd0, 3'd0, 3'd2);
        start_program();
        apply_stimulus(0);
        idx = -1;
        for (int i = 0; i < addr_trace.size(); i++) begin
            if (addr_trace[i] == 16'd4) begin
                idx = i;
                break;
            end
        end
        if (idx < 0 || idx + 3 >= addr_trace.size()) begin
            total++;
            bad++;
            $display("[TB] FAIL bnz_trace: got no fetch of 4 followed by three more, expected 4,5,6,1");
        end else begin
            check_output("bnz_seq_a", addr_trace[idx + 1], 16'd5);
            check_output("bnz_seq_b", addr_trace[idx + 2], 16'd6);
            check_output("bnz_seq_c", addr_trace[idx + 3], 16'd1);
        end

        $display("[TB] fibonacci loop");
        init_mem(16'h5555);
        load_fib();
        start_program();
        apply_stimulus(0);

        $display("[TB] fibonacci with freeze and mid-run reset");
        init_mem(16'h6666);
        load_fib();
        start_program();
        step_cycles(15, 1'b1);
        step_cycles(5, 1'b0);
        step_cycles(10, 1'b1);
        @(posedge clock);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1 rst = 1'b0;
        check_output("midrst_imem_addr", imem_addr, 16'd0);
        check_output("midrst_dmem_we", {15'd0, dmem_we}, 16'd0);
        check_output("midrst_dmem_addr", dmem_addr, 16'd0);
        check_output("midrst_dmem_dout", dmem_dout, 16'd0);
        run_model(exp_halt);
        apply_stimulus(0);

        for (int t = 0; t < 6; t++) begin
            $display("[TB] random program %0d", t);
            init_mem(16'(t * 7919 + 17));
            gen_random(40 + t * 3);
            start_program();
            apply_stimulus(t % 2 == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
